// File: rtl/controle_pkg.sv
// Shared encodings for the iZero multi-cycle control unit: opcodes, func codes,
// ALU codes, FSM states, instruction classes and the per-instruction decode record.
package controle_pkg;

    localparam logic [5:0] OP_RTYPE      = 6'd0;
    localparam logic [5:0] OP_ADDI       = 6'd1;
    localparam logic [5:0] OP_SUBI       = 6'd2;
    localparam logic [5:0] OP_MULI       = 6'd3;
    localparam logic [5:0] OP_DIVI       = 6'd4;
    localparam logic [5:0] OP_MODI       = 6'd5;
    localparam logic [5:0] OP_ANDI       = 6'd6;
    localparam logic [5:0] OP_ORI        = 6'd7;
    localparam logic [5:0] OP_XORI       = 6'd8;
    localparam logic [5:0] OP_SLTI       = 6'd9;
    localparam logic [5:0] OP_LW         = 6'd17;
    localparam logic [5:0] OP_SW         = 6'd18;
    localparam logic [5:0] OP_LDK        = 6'd19;
    localparam logic [5:0] OP_SDK        = 6'd20;
    localparam logic [5:0] OP_JF         = 6'd21;
    localparam logic [5:0] OP_J          = 6'd22;
    localparam logic [5:0] OP_JAL        = 6'd23;
    localparam logic [5:0] OP_IN         = 6'd24;
    localparam logic [5:0] OP_OUT        = 6'd25;
    localparam logic [5:0] OP_NOP        = 6'd26;
    localparam logic [5:0] OP_PRE_IO     = 6'd56;
    localparam logic [5:0] OP_SYSCALL    = 6'd57;
    localparam logic [5:0] OP_EXEC       = 6'd58;
    localparam logic [5:0] OP_EXEC_AGAIN = 6'd59;
    localparam logic [5:0] OP_HALT       = 6'd63;

    localparam logic [5:0] FN_ADD = 6'd0;
    localparam logic [5:0] FN_SUB = 6'd1;
    localparam logic [5:0] FN_MUL = 6'd2;
    localparam logic [5:0] FN_DIV = 6'd3;
    localparam logic [5:0] FN_MOD = 6'd4;
    localparam logic [5:0] FN_AND = 6'd5;
    localparam logic [5:0] FN_OR  = 6'd6;
    localparam logic [5:0] FN_XOR = 6'd7;
    localparam logic [5:0] FN_SLT = 6'd8;
    localparam logic [5:0] FN_SLL = 6'd9;
    localparam logic [5:0] FN_SRL = 6'd10;
    localparam logic [5:0] FN_JR  = 6'd16;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_MUL   = 5'd2;
    localparam logic [4:0] ALU_DIV   = 5'd3;
    localparam logic [4:0] ALU_MOD   = 5'd4;
    localparam logic [4:0] ALU_AND   = 5'd5;
    localparam logic [4:0] ALU_OR    = 5'd6;
    localparam logic [4:0] ALU_XOR   = 5'd7;
    localparam logic [4:0] ALU_SLT   = 5'd8;
    localparam logic [4:0] ALU_SLL   = 5'd9;
    localparam logic [4:0] ALU_SRL   = 5'd10;
    localparam logic [4:0] ALU_PASSA = 5'd15;

    localparam logic [1:0] PCS_NEXT   = 2'b00;
    localparam logic [1:0] PCS_TARGET = 2'b01;
    localparam logic [1:0] PCS_REG    = 2'b10;
    localparam logic [1:0] PCS_VEC    = 2'b11;

    localparam logic [1:0] RD_RD = 2'b00;
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [2:0] WS_ALU   = 3'd0;
    localparam logic [2:0] WS_MEM   = 3'd1;
    localparam logic [2:0] WS_DISK  = 3'd2;
    localparam logic [2:0] WS_INPUT = 3'd3;
    localparam logic [2:0] WS_LINK  = 3'd4;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_INPUT, S_WB, S_INTR, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_ALU_R, C_ALU_I, C_MULDIV, C_LOAD, C_STORE, C_IN, C_OUT,
        C_JUMP, C_JR, C_JF, C_MODE, C_HALT
    } class_t;

    typedef struct packed {
        class_t cls;
        logic   disk;
        logic   link;
        logic   mode_set;
        logic   mode_clr;
        logic   wb_inta;
    } dec_t;

endpackage

// File: rtl/controle_multiciclo_decodificador.sv
// Purely combinational op/func decoder: instruction class plus the static
// datapath selects (aluOp, regDest, regWrtSelect) for one instruction.
module decodificador_classe
    import controle_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int FUNC_W  = 6,
    parameter int ALUOP_W = 5
) (
    input  logic [OP_W-1:0]    i_op,
    input  logic [FUNC_W-1:0]  i_func,
    output dec_t               o_dec,
    output logic [ALUOP_W-1:0] o_aluOp,
    output logic [1:0]         o_regDest,
    output logic [2:0]         o_regWrtSelect
);

    always_comb begin
        o_dec          = '0;
        o_dec.cls      = C_NOP;
        o_aluOp        = ALUOP_W'(ALU_ADD);
        o_regDest      = RD_RD;
        o_regWrtSelect = WS_ALU;
        case (i_op)
            OP_W'(OP_RTYPE): begin
                case (i_func)
                    FUNC_W'(FN_ADD): begin o_dec.cls = C_ALU_R;  o_aluOp = ALUOP_W'(ALU_ADD);   end
                    FUNC_W'(FN_SUB): begin o_dec.cls = C_ALU_R;  o_aluOp = ALUOP_W'(ALU_SUB);   end
                    FUNC_W'(FN_MUL): begin o_dec.cls = C_MULDIV; o_aluOp = ALUOP_W'(ALU_MUL);   end
                    FUNC_W'(FN_DIV): begin o_dec.cls = C_MULDIV; o_aluOp = ALUOP_W'(ALU_DIV);   end
                    FUNC_W'(FN_MOD): begin o_dec.cls = C_MULDIV; o_aluOp = ALUOP_W'(ALU_MOD);   end
                    FUNC_W'(FN_AND): begin o_dec.cls = C_ALU_R;  o_aluOp = ALUOP_W'(ALU_AND);   end
                    FUNC_W'(FN_OR):  begin o_dec.cls = C_ALU_R;  o_aluOp = ALUOP_W'(ALU_OR);    end
                    FUNC_W'(FN_XOR): begin o_dec.cls = C_ALU_R;  o_aluOp = ALUOP_W'(ALU_XOR);   end
                    FUNC_W'(FN_SLT): begin o_dec.cls = C_ALU_R;  o_aluOp = ALUOP_W'(ALU_SLT);   end
                    FUNC_W'(FN_SLL): begin o_dec.cls = C_ALU_R;  o_aluOp = ALUOP_W'(ALU_SLL);   end
                    FUNC_W'(FN_SRL): begin o_dec.cls = C_ALU_R;  o_aluOp = ALUOP_W'(ALU_SRL);   end
                    FUNC_W'(FN_JR):  begin o_dec.cls = C_JR;     o_aluOp = ALUOP_W'(ALU_PASSA); end
                    default: ;
                endcase
            end
            OP_W'(OP_ADDI): begin o_dec.cls = C_ALU_I;  o_aluOp = ALUOP_W'(ALU_ADD); o_regDest = RD_RT; end
            OP_W'(OP_SUBI): begin o_dec.cls = C_ALU_I;  o_aluOp = ALUOP_W'(ALU_SUB); o_regDest = RD_RT; end
            OP_W'(OP_MULI): begin o_dec.cls = C_MULDIV; o_aluOp = ALUOP_W'(ALU_MUL); o_regDest = RD_RT; end
            OP_W'(OP_DIVI): begin o_dec.cls = C_MULDIV; o_aluOp = ALUOP_W'(ALU_DIV); o_regDest = RD_RT; end
            OP_W'(OP_MODI): begin o_dec.cls = C_MULDIV; o_aluOp = ALUOP_W'(ALU_MOD); o_regDest = RD_RT; end
            OP_W'(OP_ANDI): begin o_dec.cls = C_ALU_I;  o_aluOp = ALUOP_W'(ALU_AND); o_regDest = RD_RT; end
            OP_W'(OP_ORI):  begin o_dec.cls = C_ALU_I;  o_aluOp = ALUOP_W'(ALU_OR);  o_regDest = RD_RT; end
            OP_W'(OP_XORI): begin o_dec.cls = C_ALU_I;  o_aluOp = ALUOP_W'(ALU_XOR); o_regDest = RD_RT; end
            OP_W'(OP_SLTI): begin o_dec.cls = C_ALU_I;  o_aluOp = ALUOP_W'(ALU_SLT); o_regDest = RD_RT; end
            OP_W'(OP_LW):  begin o_dec.cls = C_LOAD; o_regDest = RD_RT; o_regWrtSelect = WS_MEM; end
            OP_W'(OP_SW):  o_dec.cls = C_STORE;
            OP_W'(OP_LDK): begin
                o_dec.cls = C_LOAD; o_dec.disk = 1'b1; o_regDest = RD_RT; o_regWrtSelect = WS_DISK;
            end
            OP_W'(OP_SDK): begin o_dec.cls = C_STORE; o_dec.disk = 1'b1; end
            OP_W'(OP_JF):  begin o_dec.cls = C_JF; o_aluOp = ALUOP_W'(ALU_PASSA); end
            OP_W'(OP_J):   o_dec.cls = C_JUMP;
            OP_W'(OP_JAL): begin
                o_dec.cls = C_JUMP; o_dec.link = 1'b1; o_regDest = RD_RA; o_regWrtSelect = WS_LINK;
            end
            OP_W'(OP_IN):  begin o_dec.cls = C_IN; o_regDest = RD_RT; o_regWrtSelect = WS_INPUT; end
            OP_W'(OP_OUT): begin o_dec.cls = C_OUT; o_aluOp = ALUOP_W'(ALU_PASSA); end
            OP_W'(OP_NOP): o_dec.cls = C_NOP;
            OP_W'(OP_PRE_IO):     begin o_dec.cls = C_MODE; o_dec.wb_inta  = 1'b1; end
            OP_W'(OP_SYSCALL):    begin o_dec.cls = C_MODE; o_dec.mode_clr = 1'b1; end
            OP_W'(OP_EXEC):       begin o_dec.cls = C_MODE; o_dec.mode_set = 1'b1; end
            OP_W'(OP_EXEC_AGAIN): begin o_dec.cls = C_MODE; o_dec.mode_set = 1'b1; end
            OP_W'(OP_HALT): o_dec.cls = C_HALT;
            default: ;
        endcase
    end

endmodule

// File: rtl/controle_multiciclo.sv
// iZero multi-cycle control unit: FSM, MUL/DIV latency counter and user/kernel mode bit.
// Optional MEM-state timeout with bus_err is built when CTRL_MEM_TIMEOUT_EN is defined.
module controle_multiciclo
    import controle_pkg::*;
#(
    parameter int OP_W        = 6,
    parameter int FUNC_W      = 6,
    parameter int ALUOP_W     = 5,
    parameter int MULDIV_LAT  = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    op,
    input  logic [FUNC_W-1:0]  func,
    input  logic               isFalse,
    input  logic               isInput,
    input  logic               intr,
    input  logic               mem_ready,
    output logic               irWrite,
    output logic               pcWrite,
    output logic               regWrite,
    output logic               memWrite,
    output logic               diskWrite,
    output logic               outWrite,
    output logic               inta,
    output logic               isHalt,
    output logic               isInsert,
    output logic               busy,
    output logic               userMode,
    output logic               bus_err,
    output logic [1:0]         pcSource,
    output logic [1:0]         regDest,
    output logic [2:0]         regWrtSelect,
    output logic [ALUOP_W-1:0] aluOp
);

    localparam int CW = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;

    if (MULDIV_LAT < 1 || MEM_TIMEOUT < 1) begin : g_bad_param
        $error("controle_multiciclo: MULDIV_LAT and MEM_TIMEOUT must be >= 1");
    end

    state_t               r_state, w_next;
    dec_t                 r_dec, w_dec;
    logic [ALUOP_W-1:0]   r_aluOp, w_aluOp;
    logic [1:0]           r_regDest, w_regDest;
    logic [2:0]           r_regWrtSelect, w_regWrtSelect;
    logic [CW-1:0]        r_cnt;
    logic                 r_userMode, w_userMode;
    logic                 w_timeout;

    decodificador_classe #(
        .OP_W   (OP_W),
        .FUNC_W (FUNC_W),
        .ALUOP_W(ALUOP_W)
    ) u_dec (
        .i_op          (op),
        .i_func        (func),
        .o_dec         (w_dec),
        .o_aluOp       (w_aluOp),
        .o_regDest     (w_regDest),
        .o_regWrtSelect(w_regWrtSelect)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_FETCH;
            r_dec          <= '0;
            r_aluOp        <= '0;
            r_regDest      <= '0;
            r_regWrtSelect <= '0;
            r_cnt          <= '0;
            r_userMode     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_userMode <= w_userMode;
            if (r_state == S_DECODE) begin
                r_dec          <= w_dec;
                r_aluOp        <= w_aluOp;
                r_regDest      <= w_regDest;
                r_regWrtSelect <= w_regWrtSelect;
                r_cnt          <= CW'(MULDIV_LAT - 1);
            end else if (r_state == S_EXEC && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

`ifdef CTRL_MEM_TIMEOUT_EN
    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    logic [TW-1:0] r_tcnt;

    // r_tcnt holds the number of MEM cycles already spent before the current one
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  r_tcnt <= '0;
        else if (r_state == S_MEM) r_tcnt <= r_tcnt + 1'b1;
        else                      r_tcnt <= '0;
    end

    assign w_timeout = (r_state == S_MEM) && !mem_ready && (r_tcnt == TW'(MEM_TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    assign userMode     = r_userMode;
    assign aluOp        = r_aluOp;
    assign regDest      = r_regDest;
    assign regWrtSelect = r_regWrtSelect;

    always_comb begin
        w_next     = r_state;
        w_userMode = r_userMode;
        irWrite    = 1'b0;
        pcWrite    = 1'b0;
        regWrite   = 1'b0;
        memWrite   = 1'b0;
        diskWrite  = 1'b0;
        outWrite   = 1'b0;
        inta       = 1'b0;
        isHalt     = 1'b0;
        isInsert   = 1'b0;
        busy       = 1'b0;
        bus_err    = 1'b0;
        pcSource   = PCS_NEXT;
        // Outputs are forced low for as long as reset is held, including FETCH's irWrite
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    irWrite = 1'b1;
                    w_next  = S_DECODE;
                end
                S_DECODE: w_next = S_EXEC;
                S_EXEC: begin
                    if (r_dec.cls == C_MULDIV) busy = 1'b1;
                    if (r_dec.cls == C_MULDIV && r_cnt != '0) w_next = S_EXEC;
                    else begin
                        case (r_dec.cls)
                            C_LOAD, C_STORE: w_next = S_MEM;
                            C_IN:            w_next = S_INPUT;
                            C_HALT:          w_next = S_HALT;
                            default:         w_next = S_WB;
                        endcase
                    end
                end
                S_MEM: begin
                    busy = 1'b1;
                    if (w_timeout) begin
                        bus_err = 1'b1;
                        w_next  = S_INTR;
                    end else begin
                        memWrite  = (r_dec.cls == C_STORE) && !r_dec.disk;
                        diskWrite = (r_dec.cls == C_STORE) &&  r_dec.disk;
                        if (mem_ready) w_next = S_WB;
                    end
                end
                S_INPUT: begin
                    isInsert = 1'b1;
                    busy     = 1'b1;
                    if (isInput) w_next = S_WB;
                end
                S_WB: begin
                    pcWrite  = 1'b1;
                    regWrite = (r_dec.cls inside {C_ALU_R, C_ALU_I, C_MULDIV, C_LOAD, C_IN}) ||
                               (r_dec.cls == C_JUMP && r_dec.link);
                    outWrite = (r_dec.cls == C_OUT);
                    inta     = r_dec.wb_inta;
                    case (r_dec.cls)
                        C_JUMP:  pcSource = PCS_TARGET;
                        C_JF:    pcSource = isFalse ? PCS_TARGET : PCS_NEXT;
                        C_JR:    pcSource = PCS_REG;
                        default: pcSource = PCS_NEXT;
                    endcase
                    if (r_dec.mode_set) w_userMode = 1'b1;
                    if (r_dec.mode_clr) w_userMode = 1'b0;
                    w_next = intr ? S_INTR : S_FETCH;
                end
                S_INTR: begin
                    inta       = 1'b1;
                    pcWrite    = 1'b1;
                    pcSource   = PCS_VEC;
                    w_userMode = 1'b0;
                    w_next     = S_FETCH;
                end
                S_HALT: isHalt = 1'b1;
                default: w_next = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Randomized self-checking bench: an instruction-level reference model predicts the
// full output vector of every cycle from per-instruction properties and wait times.
module tb_controle_multiciclo;

    localparam int LAT = 4;
    localparam int TMO = 8;
`ifdef CTRL_MEM_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = '0, func = '0;
    logic       isFalse = 1'b0, isInput = 1'b0, intr = 1'b0, mem_ready = 1'b0;
    logic       irWrite, pcWrite, regWrite, memWrite, diskWrite, outWrite, inta;
    logic       isHalt, isInsert, busy, userMode, bus_err;
    logic [1:0] pcSource, regDest;
    logic [2:0] regWrtSelect;
    logic [4:0] aluOp;

    controle_multiciclo #(
        .OP_W(6), .FUNC_W(6), .ALUOP_W(5), .MULDIV_LAT(LAT), .MEM_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .op(op), .func(func), .isFalse(isFalse), .isInput(isInput),
        .intr(intr), .mem_ready(mem_ready), .irWrite(irWrite), .pcWrite(pcWrite),
        .regWrite(regWrite), .memWrite(memWrite), .diskWrite(diskWrite), .outWrite(outWrite),
        .inta(inta), .isHalt(isHalt), .isInsert(isInsert), .busy(busy), .userMode(userMode),
        .bus_err(bus_err), .pcSource(pcSource), .regDest(regDest), .regWrtSelect(regWrtSelect),
        .aluOp(aluOp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Output vector bit positions
    localparam int B_IRW = 23, B_PCW = 22, B_RGW = 21, B_MW = 20, B_DW = 19, B_OW = 18;
    localparam int B_INTA = 17, B_HLT = 16, B_INS = 15, B_BSY = 14, B_UM = 13, B_BERR = 12;

    task automatic check_eq(input string tag, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] observed();
        return {irWrite, pcWrite, regWrite, memWrite, diskWrite, outWrite, inta, isHalt,
                isInsert, busy, userMode, bus_err, pcSource, regDest, regWrtSelect, aluOp};
    endfunction

    // Reference-model architectural state
    bit         m_um;
    logic [4:0] m_alu;
    logic [1:0] m_rd;
    logic [2:0] m_ws;

    function automatic logic [23:0] base();
        logic [23:0] e = '0;
        e[B_UM] = m_um;
        e[9:8]  = m_rd;
        e[7:5]  = m_ws;
        e[4:0]  = m_alu;
        return e;
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    typedef struct {
        int ex; bit md; int mem; bit disk; bit inp; bit halt; bit rw; bit ow;
        int pcs; bit inta; int mode; logic [4:0] alu; logic [1:0] rd; logic [2:0] ws;
    } info_t;

    // mem: 0 none, 1 load, 2 store; pcs: 0 next, 1 target, 2 reg, 3 target-if-false; mode: 1 set, 2 clear
    function automatic info_t lookup(input int o, input int f);
        info_t i = '{default: 0};
        i.ex = 1;
        if (o == 0) begin
            if (f <= 10) begin
                i.rw = 1; i.alu = 5'(f);
                if (f >= 2 && f <= 4) begin i.ex = LAT; i.md = 1; end
            end else if (f == 16) begin
                i.pcs = 2; i.alu = 5'd15;
            end
        end else if (o >= 1 && o <= 9) begin
            i.rw = 1; i.alu = 5'(o - 1); i.rd = 2'd1;
            if (o >= 3 && o <= 5) begin i.ex = LAT; i.md = 1; end
        end else begin
            case (o)
                17: begin i.mem = 1; i.rw = 1; i.rd = 2'd1; i.ws = 3'd1; end
                18: i.mem = 2;
                19: begin i.mem = 1; i.disk = 1; i.rw = 1; i.rd = 2'd1; i.ws = 3'd2; end
                20: begin i.mem = 2; i.disk = 1; end
                21: begin i.pcs = 3; i.alu = 5'd15; end
                22: i.pcs = 1;
                23: begin i.pcs = 1; i.rw = 1; i.rd = 2'd2; i.ws = 3'd4; end
                24: begin i.inp = 1; i.rw = 1; i.rd = 2'd1; i.ws = 3'd3; end
                25: begin i.ow = 1; i.alu = 5'd15; end
                56: i.inta = 1;
                57: i.mode = 2;
                58, 59: i.mode = 1;
                63: i.halt = 1;
                default: ;
            endcase
        end
        return i;
    endfunction

    task automatic do_cycle(input bit mr, input bit ii, input bit it, input bit fl,
                            input logic [5:0] o, input logic [5:0] f,
                            input logic [23:0] e, input string tag);
        @(negedge clk);
        mem_ready = mr; isInput = ii; intr = it; isFalse = fl; op = o; func = f;
        #1;
        check_eq(tag, observed(), e);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        m_um = 1'b0; m_alu = '0; m_rd = '0; m_ws = '0;
        @(negedge clk);
        #1 check_eq("reset", observed(), '0);
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // Negative wait/flag arguments mean "pick at random"
    task automatic run_instr(input int o, input int f, input int mw_in, input int iw_in,
                             input int fl_in, input int wbi_in, input bit abort_mem);
        info_t       in;
        logic [23:0] e;
        int          mw, iw, pcs;
        bit          fl, wbi;
        in  = lookup(o, f);
        mw  = (mw_in < 0) ? int'($urandom_range(0, 3)) : mw_in;
        iw  = (iw_in < 0) ? int'($urandom_range(0, 3)) : iw_in;
        fl  = (fl_in < 0) ? rb() : 1'(fl_in);
        wbi = (wbi_in < 0) ? ($urandom_range(0, 3) == 0) : 1'(wbi_in);

        e = base(); e[B_IRW] = 1'b1;
        do_cycle(rb(), rb(), rb(), rb(), 6'(o), 6'(f), e, "fetch");
        e = base();
        do_cycle(rb(), rb(), rb(), rb(), 6'(o), 6'(f), e, "decode");
        m_alu = in.alu; m_rd = in.rd; m_ws = in.ws;

        for (int k = 0; k < in.ex; k++) begin
            e = base(); e[B_BSY] = in.md;
            do_cycle(rb(), rb(), rb(), rb(), 6'($urandom), 6'($urandom), e, "exec");
        end

        if (in.halt) begin
            for (int k = 0; k < 6; k++) begin
                e = base(); e[B_HLT] = 1'b1;
                do_cycle(rb(), rb(), rb(), rb(), 6'($urandom), 6'($urandom), e, "halt");
            end
            return;
        end

        if (in.mem != 0) begin
            for (int k = 0; k <= mw; k++) begin
                bit rdy = (k == mw);
                e = base(); e[B_BSY] = 1'b1;
                if (TMO_EN && k == TMO - 1 && !rdy) begin
                    e[B_BERR] = 1'b1;
                    do_cycle(1'b0, rb(), rb(), rb(), 6'($urandom), 6'($urandom), e, "mem_timeout");
                    e = base(); e[B_INTA] = 1'b1; e[B_PCW] = 1'b1; e[11:10] = 2'b11;
                    do_cycle(rb(), rb(), rb(), rb(), 6'($urandom), 6'($urandom), e, "timeout_intr");
                    m_um = 1'b0;
                    return;
                end
                if (in.mem == 2) begin
                    if (in.disk) e[B_DW] = 1'b1;
                    else         e[B_MW] = 1'b1;
                end
                do_cycle(rdy, rb(), rb(), rb(), 6'($urandom), 6'($urandom), e, "mem");
                if (abort_mem) begin
                    rst = 1'b1;
                    #1 check_eq("abort_reset", observed(), '0);
                    apply_reset();
                    return;
                end
            end
        end

        if (in.inp) begin
            for (int k = 0; k <= iw; k++) begin
                e = base(); e[B_INS] = 1'b1; e[B_BSY] = 1'b1;
                do_cycle(rb(), (k == iw), rb(), rb(), 6'($urandom), 6'($urandom), e, "input");
            end
        end

        pcs = (in.pcs == 3) ? (fl ? 1 : 0) : in.pcs;
        e = base();
        e[B_PCW] = 1'b1; e[B_RGW] = in.rw; e[B_OW] = in.ow; e[B_INTA] = in.inta;
        e[11:10] = 2'(pcs);
        do_cycle(rb(), rb(), wbi, fl, 6'($urandom), 6'($urandom), e, "wb");
        if (in.mode == 1) m_um = 1'b1;
        if (in.mode == 2) m_um = 1'b0;

        if (wbi) begin
            e = base(); e[B_INTA] = 1'b1; e[B_PCW] = 1'b1; e[11:10] = 2'b11;
            do_cycle(rb(), rb(), rb(), rb(), 6'($urandom), 6'($urandom), e, "intr");
            m_um = 1'b0;
        end
    endtask

    int ops[25] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 17, 18, 19, 20, 21, 22, 23, 24, 25, 26,
                    40, 56, 57, 58, 59};
    int rfn[13] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 16, 30};

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        apply_reset();
        run_instr(0, 0, -1, -1, -1, 0, 1'b0);    // add
        run_instr(0, 3, -1, -1, -1, 0, 1'b0);    // div
        run_instr(18, 0, 3, -1, -1, 0, 1'b0);    // sw, ready 3 cycles after MEM entry
        run_instr(58, 0, -1, -1, -1, 0, 1'b0);   // exec -> user mode
        run_instr(0, 2, -1, -1, -1, 1, 1'b0);    // mul, interrupt taken after WB
        run_instr(58, 0, -1, -1, -1, 0, 1'b0);
        run_instr(57, 0, -1, -1, -1, 0, 1'b0);   // syscall -> kernel mode
        run_instr(21, 0, -1, -1, 0, 0, 1'b0);    // jf with isFalse=0
        run_instr(21, 0, -1, -1, 1, 0, 1'b0);    // jf with isFalse=1
        run_instr(24, 0, -1, 2, -1, 0, 1'b0);    // in, waits for confirm

        for (int n = 0; n < 150; n++) begin
            int o, f;
            o = ops[$urandom_range(0, 24)];
            f = (o == 0) ? rfn[$urandom_range(0, 12)] : int'($urandom_range(0, 63));
            run_instr(o, f, -1, -1, -1, -1, 1'b0);
        end

        run_instr(18, 0, 3, -1, -1, 0, 1'b1);    // reset while a store waits in MEM
        run_instr(0, 1, -1, -1, -1, 0, 1'b0);
`ifdef CTRL_MEM_TIMEOUT_EN
        run_instr(17, 0, 20, -1, -1, 0, 1'b0);
        run_instr(18, 0, 20, -1, -1, 0, 1'b0);
`endif
        run_instr(63, 0, -1, -1, -1, 0, 1'b0);   // halt until reset
        apply_reset();
        run_instr(0, 0, -1, -1, -1, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
